// File: rtl/tetris_pkg.sv
// Shared board geometry, cell and piece types for the Tetris display pipeline.
package tetris_pkg;

    localparam int unsigned BOARD_COLS  = 10;
    localparam int unsigned BOARD_ROWS  = 20;
    localparam int unsigned CELL_W      = 16;
    localparam int unsigned PIECE_CELLS = 4;
    localparam int unsigned PX_W        = 4;
    localparam int unsigned PY_W        = 5;

    typedef logic [CELL_W-1:0] cell_t;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} fetch_state_t;

    typedef struct packed {
        logic [PIECE_CELLS-1:0][PX_W-1:0] x;
        logic [PIECE_CELLS-1:0][PY_W-1:0] y;
        cell_t                            color;
    } piece_t;

endpackage

// File: rtl/piece_cell_match.sv
// Combinational test of whether board cell (row, col) is covered by a piece cell.
module piece_cell_match
    import tetris_pkg::*;
(
    input  logic [7:0]                     i_row,
    input  logic [3:0]                     i_col,
    input  logic                           i_valid,
    input  logic [PIECE_CELLS-1:0][PX_W-1:0] i_x,
    input  logic [PIECE_CELLS-1:0][PY_W-1:0] i_y,
    output logic                           o_hit_c
);

    always_comb begin
        o_hit_c = 1'b0;
        for (int i = 0; i < int'(PIECE_CELLS); i++) begin
            if (i_valid && ({3'b000, i_y[i]} == i_row) && (i_x[i] == i_col)) begin
                o_hit_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_row_fetcher.sv
// Fetches one board row from RAM (fixed 12-cycle latency) into a double-buffered Row bank.
// Falling-piece overlay is built only when PIECE_OVERLAY_EN is defined.
module board_row_fetcher
    import tetris_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
)
(
    input  logic                           Clk,
    input  logic                           reset,
    input  logic                           LD_Row,
    input  logic [7:0]                     rowNum,
    output logic                           mem_rd,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [15:0]                    mem_rdata,
    input  logic                           piece_valid,
    input  logic [PIECE_CELLS-1:0][PX_W-1:0] piece_x,
    input  logic [PIECE_CELLS-1:0][PY_W-1:0] piece_y,
    input  logic [15:0]                    piece_color,
    output cell_t [BOARD_COLS-1:0]         Row,
    output logic                           rowReady,
    output logic                           overrun
);

    fetch_state_t              r_state;
    fetch_state_t              w_state_next;
    logic                      r_ld_q;
    logic                      w_req;
    logic                      r_in_range;
    logic                      w_rn_in_range;
    logic [ADDR_W-1:0]         w_row_base;
    logic [3:0]                r_col;
    logic                      r_cap_en;
    logic [3:0]                r_cap_col;
    cell_t [BOARD_COLS-1:0]    r_shadow;
    cell_t [BOARD_COLS-1:0]    w_shadow_next;
    cell_t                     w_cell;

    assign w_req         = LD_Row & ~r_ld_q;
    assign w_rn_in_range = (rowNum < 8'(BOARD_ROWS));
    // row*10 as (row<<3)+(row<<1)
    assign w_row_base    = ADDR_W'({rowNum, 3'b000}) + ADDR_W'({rowNum, 1'b0});

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_state_next = FETCH;
            FETCH:   if (r_col == 4'(BOARD_COLS - 1)) w_state_next = DRAIN;
            DRAIN:   w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

`ifdef PIECE_OVERLAY_EN
    logic [7:0] r_cur_row;
    logic       r_piece_valid;
    piece_t     r_piece;
    logic       w_hit;

    // Snapshot taken at request time so piece moves never tear a row.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_cur_row     <= '0;
            r_piece_valid <= 1'b0;
            r_piece       <= '0;
        end else if (r_state == IDLE && w_req) begin
            r_cur_row     <= rowNum;
            r_piece_valid <= piece_valid;
            r_piece.x     <= piece_x;
            r_piece.y     <= piece_y;
            r_piece.color <= piece_color;
        end
    end

    piece_cell_match u_match (
        .i_row   (r_cur_row),
        .i_col   (r_cap_col),
        .i_valid (r_piece_valid),
        .i_x     (r_piece.x),
        .i_y     (r_piece.y),
        .o_hit_c (w_hit)
    );

    assign w_cell = !r_in_range ? '0 : (w_hit ? r_piece.color : mem_rdata);
`else
    logic w_unused_piece;
    assign w_unused_piece = ^{piece_valid, piece_x, piece_y, piece_color};
    assign w_cell         = r_in_range ? mem_rdata : '0;
`endif

    always_comb begin
        w_shadow_next            = r_shadow;
        w_shadow_next[r_cap_col] = w_cell;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_ld_q     <= 1'b0;
            r_in_range <= 1'b0;
            r_col      <= '0;
            r_cap_en   <= 1'b0;
            r_cap_col  <= '0;
            r_shadow   <= '0;
            Row        <= '0;
            rowReady   <= 1'b0;
            overrun    <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
        end else begin
            r_ld_q    <= LD_Row;
            overrun   <= w_req && (r_state != IDLE);
            rowReady  <= (r_state == DRAIN);
            r_cap_en  <= (r_state == FETCH);
            r_cap_col <= r_col;

            if (r_state == IDLE && w_req) begin
                r_in_range <= w_rn_in_range;
                r_col      <= '0;
                mem_rd     <= w_rn_in_range;
                mem_addr   <= w_rn_in_range ? w_row_base : '0;
            end else if (r_state == FETCH) begin
                if (r_col == 4'(BOARD_COLS - 1)) begin
                    r_col    <= '0;
                    mem_rd   <= 1'b0;
                    mem_addr <= '0;
                end else begin
                    r_col <= r_col + 4'd1;
                    if (r_in_range) mem_addr <= mem_addr + ADDR_W'(1);
                end
            end

            // Last cell lands in DRAIN; it is merged straight into the committed bank.
            if (r_cap_en) r_shadow <= w_shadow_next;
            if (r_state == DRAIN) Row <= w_shadow_next;
        end
    end

endmodule

// File: tb/tb_board_row_fetcher.sv
// Directed self-checking bench for board_row_fetcher; overlay expectations follow PIECE_OVERLAY_EN.
module tb_board_row_fetcher;
    import tetris_pkg::*;

    localparam int unsigned ADDR_W = 8;
    localparam int NK = 16;

    logic                     Clk = 1'b0;
    logic                     reset;
    logic                     LD_Row;
    logic [7:0]               rowNum;
    logic                     mem_rd;
    logic [ADDR_W-1:0]        mem_addr;
    logic [15:0]              mem_rdata;
    logic                     piece_valid;
    logic [3:0][3:0]          piece_x;
    logic [3:0][4:0]          piece_y;
    logic [15:0]              piece_color;
    cell_t [BOARD_COLS-1:0]   Row;
    logic                     rowReady;
    logic                     overrun;

    logic [15:0]              mem [256];
    int                       n_pass  = 0;
    int                       n_total = 0;

    logic                     rec_rd   [NK+1];
    logic [7:0]               rec_addr [NK+1];
    logic                     rec_rdy  [NK+1];
    logic                     rec_ovr  [NK+1];
    cell_t [BOARD_COLS-1:0]   rec_row  [NK+1];
    logic [3:0][3:0]          alt_x;
    logic [3:0][4:0]          alt_y;
    int                       move_k = -1;

    board_row_fetcher #(.ADDR_W(ADDR_W)) dut (
        .Clk         (Clk),
        .reset       (reset),
        .LD_Row      (LD_Row),
        .rowNum      (rowNum),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .piece_valid (piece_valid),
        .piece_x     (piece_x),
        .piece_y     (piece_y),
        .piece_color (piece_color),
        .Row         (Row),
        .rowReady    (rowReady),
        .overrun     (overrun)
    );

    always #10 Clk = ~Clk;

    // Synchronous-read RAM; returns garbage when not strobed.
    always @(posedge Clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        else        mem_rdata <= 16'hDEAD;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_request(input logic [7:0] row, input logic [NK-1:0] sched);
        rowNum = row;
        for (int k = 0; k < NK; k++) begin
            LD_Row = sched[k];
            if (k == move_k) begin
                piece_x = alt_x;
                piece_y = alt_y;
            end
            tick();
            rec_rd[k+1]   = mem_rd;
            rec_addr[k+1] = mem_addr;
            rec_rdy[k+1]  = rowReady;
            rec_ovr[k+1]  = overrun;
            rec_row[k+1]  = Row;
        end
        LD_Row = 1'b0;
    endtask

    task automatic set_piece();
        piece_y[0] = 5'd4; piece_x[0] = 4'd5;
        piece_y[1] = 5'd4; piece_x[1] = 4'd6;
        piece_y[2] = 5'd5; piece_x[2] = 4'd5;
        piece_y[3] = 5'd3; piece_x[3] = 4'd0;
        piece_color = 16'h0F00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_total++;
        if (Row !== '0) $display("FAIL reset_row got=%h exp=0", Row);
        else n_pass++;
        n_total++;
        if ({mem_rd, rowReady, overrun} !== 3'b000)
            $display("FAIL reset_strobes got rd=%b rdy=%b ovr=%b exp=000", mem_rd, rowReady, overrun);
        else n_pass++;
        n_total++;
        if (mem_addr !== 8'h00) $display("FAIL reset_addr got=%h exp=00", mem_addr);
        else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_row_fetch(input logic [7:0] row);
        int r = int'(row);
        logic inr = (r < 20);
        cell_t [BOARD_COLS-1:0] prev_row = Row;
        cell_t [BOARD_COLS-1:0] exp_row;
        piece_valid = 1'b0;
        do_request(row, 16'h0001);
        for (int k = 1; k <= NK; k++) begin
            logic       e_rd  = inr && (k <= 10);
            logic [7:0] e_adr = e_rd ? 8'(r * 10 + k - 1) : 8'h00;
            logic       e_rdy = (k == 12);
            n_total++;
            if (rec_rd[k] !== e_rd || rec_addr[k] !== e_adr || rec_rdy[k] !== e_rdy || rec_ovr[k] !== 1'b0)
                $display("FAIL fetch_row%0d_cyc%0d got rd=%b addr=%0d rdy=%b ovr=%b exp rd=%b addr=%0d rdy=%b ovr=0",
                         r, k, rec_rd[k], rec_addr[k], rec_rdy[k], rec_ovr[k], e_rd, e_adr, e_rdy);
            else n_pass++;
        end
        n_total++;
        if (rec_row[11] !== prev_row) $display("FAIL row%0d_early_change got=%h exp=%h", r, rec_row[11], prev_row);
        else n_pass++;
        for (int c = 0; c < 10; c++) exp_row[c] = inr ? 16'(r * 16 + c) : 16'h0000;
        n_total++;
        if (Row !== exp_row) $display("FAIL row%0d_data got=%h exp=%h", r, Row, exp_row);
        else n_pass++;
    endtask

    task automatic test_held_level();
        int n_rdy = 0, n_rd = 0, n_ovr = 0;
        cell_t [BOARD_COLS-1:0] exp_row;
        piece_valid = 1'b0;
        rowNum = 8'd2;
        LD_Row = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            n_rdy += int'(rowReady);
            n_rd  += int'(mem_rd);
            n_ovr += int'(overrun);
        end
        LD_Row = 1'b0;
        tick();
        n_total++;
        if (n_rdy != 1 || n_rd != 10 || n_ovr != 0)
            $display("FAIL held_level got rdy=%0d rd=%0d ovr=%0d exp rdy=1 rd=10 ovr=0", n_rdy, n_rd, n_ovr);
        else n_pass++;
        for (int c = 0; c < 10; c++) exp_row[c] = 16'(32 + c);
        n_total++;
        if (Row !== exp_row) $display("FAIL held_row got=%h exp=%h", Row, exp_row);
        else n_pass++;
    endtask

    task automatic test_overrun();
        cell_t [BOARD_COLS-1:0] exp_row;
        piece_valid = 1'b0;
        // Second edge mid-fetch (T+5) and a third in the COMMIT cycle (T+12).
        do_request(8'd5, 16'h1021);
        for (int k = 1; k <= NK; k++) begin
            logic       e_rd  = (k <= 10);
            logic [7:0] e_adr = e_rd ? 8'(50 + k - 1) : 8'h00;
            logic       e_ovr = (k == 6) || (k == 13);
            n_total++;
            if (rec_rd[k] !== e_rd || rec_addr[k] !== e_adr || rec_rdy[k] !== (k == 12) || rec_ovr[k] !== e_ovr)
                $display("FAIL overrun_cyc%0d got rd=%b addr=%0d rdy=%b ovr=%b exp rd=%b addr=%0d rdy=%b ovr=%b",
                         k, rec_rd[k], rec_addr[k], rec_rdy[k], rec_ovr[k], e_rd, e_adr, (k == 12), e_ovr);
            else n_pass++;
        end
        for (int c = 0; c < 10; c++) exp_row[c] = 16'(80 + c);
        n_total++;
        if (Row !== exp_row) $display("FAIL overrun_row got=%h exp=%h", Row, exp_row);
        else n_pass++;
    endtask

    task automatic test_overlay(input logic pv, input logic move);
        cell_t [BOARD_COLS-1:0] exp_row;
        set_piece();
        piece_valid = pv;
        if (move) begin
            for (int i = 0; i < 4; i++) begin
                alt_x[i] = 4'd9;
                alt_y[i] = 5'd4;
            end
            move_k = 4;
        end
        do_request(8'd4, 16'h0001);
        move_k = -1;
        for (int c = 0; c < 10; c++) begin
            exp_row[c] = 16'(64 + c);
`ifdef PIECE_OVERLAY_EN
            if (pv && (c == 5 || c == 6)) exp_row[c] = 16'h0F00;
`endif
        end
        n_total++;
        if (rec_rdy[12] !== 1'b1) $display("FAIL overlay_ready pv=%b got=%b exp=1", pv, rec_rdy[12]);
        else n_pass++;
        n_total++;
        if (Row !== exp_row) $display("FAIL overlay_row pv=%b move=%b got=%h exp=%h", pv, move, Row, exp_row);
        else n_pass++;
        piece_valid = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        int n_rdy = 0, n_rd = 0;
        rowNum = 8'd8;
        LD_Row = 1'b1;
        tick();
        LD_Row = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        #1;
        n_total++;
        if (Row !== '0 || mem_rd !== 1'b0 || rowReady !== 1'b0)
            $display("FAIL midreset_clear got row=%h rd=%b rdy=%b exp row=0 rd=0 rdy=0", Row, mem_rd, rowReady);
        else n_pass++;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            n_rdy += int'(rowReady);
            n_rd  += int'(mem_rd);
        end
        n_total++;
        if (n_rdy != 0 || n_rd != 0 || Row !== '0)
            $display("FAIL midreset_idle got rdy=%0d rd=%0d row=%h exp rdy=0 rd=0 row=0", n_rdy, n_rd, Row);
        else n_pass++;
        test_row_fetch(8'd9);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = (a < 200) ? 16'((a / 10) * 16 + (a % 10)) : 16'hBEEF;
        reset       = 1'b1;
        LD_Row      = 1'b0;
        rowNum      = 8'd0;
        piece_valid = 1'b0;
        piece_x     = '0;
        piece_y     = '0;
        piece_color = 16'h0000;
        alt_x       = '0;
        alt_y       = '0;

        test_reset();
        test_row_fetch(8'd3);
        test_row_fetch(8'd0);
        test_row_fetch(8'd19);
        test_row_fetch(8'd20);
        test_row_fetch(8'd25);
        test_held_level();
        test_overrun();
        test_overlay(1'b1, 1'b0);
        test_overlay(1'b0, 1'b0);
        test_overlay(1'b1, 1'b1);
        test_reset_mid_fetch();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/board_row_fetcher.md
Name: board_row_fetcher

Overview:
- Upstream stage of the VGA colour mapper.
- On each load request (LD_Row + rowNum) it reads one 10-cell board row from the board RAM, one cell per cycle, and optionally overlays the falling tetromino's cells.
- It commits the result atomically to the Row[10] output bank and pulses rowReady.
- The output bank is double-buffered, so the colour mapper sees a stable row for the whole block-row scan.

Parameters:
- BOARD_COLS, 10, cells per row.
- BOARD_ROWS, 20, rows on the board. rowNum >= BOARD_ROWS is out of range.
- ADDR_W, 8, board RAM address width; must satisfy BOARD_COLS*BOARD_ROWS <= 2**ADDR_W.

Ports:
- Clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high.
- LD_Row  in  1  load request level from the colour mapper; only its rising edge counts.
- rowNum  in  8  board row to fetch; sampled on the LD_Row rising edge.
- mem_rd  out  1  board RAM read strobe.
- mem_addr  out  ADDR_W  board RAM address = row*BOARD_COLS + col.
- mem_rdata  in  16  RAM cell data {4'b0,R4,G4,B4}; valid one cycle after mem_addr/mem_rd.
- piece_valid  in  1  a falling piece is present.
- piece_x  in  4x4  column of each of the 4 piece cells.
- piece_y  in  4x5  row of each of the 4 piece cells.
- piece_color  in  16  cell value used for piece cells.
- Row  out  10x16  committed row cells, index = column.
- rowReady  out  1  one-cycle pulse when Row has been updated.
- overrun  out  1  one-cycle pulse when a request arrives while busy.

Behaviour:
- Reset (async): state=IDLE; Row[*]=0; shadow buffer=0; rowReady=0; overrun=0; mem_rd=0; mem_addr=0; LD_Row edge-detect register=0.
- Edge detect: req = LD_Row & ~LD_Row_q. A level held for many cycles produces exactly one request.
- States:
  - IDLE: on req at cycle T, latch rowNum into cur_row, latch piece_valid/x/y/color into a snapshot, set col=0, go to FETCH.
  - FETCH (T+1..T+10): mem_rd=1 and mem_addr=cur_row*10+col. Compute the address as (row<<3)+(row<<1)+col; no multiplier. col increments each cycle; after col=9, go to DRAIN.
  - DRAIN (T+11): capture the last cell, then go to COMMIT.
  - COMMIT (T+12): copy shadow to Row in one cycle, rowReady=1 for this cycle only, then go to IDLE.
- Capture: cell col arrives at T+2+col. shadow[col] = overlay_hit ? snapshot color : mem_rdata. overlay_hit is true when piece_valid_snap is set and some i in 0..3 has piece_y[i]==cur_row and piece_x[i]==col.
- Fixed latency: rowReady asserts exactly 12 cycles after the req cycle, in all cases.
- Out-of-range row (cur_row >= BOARD_ROWS): timing is identical, but mem_rd stays 0 and mem_addr stays 0. Every shadow cell is forced to 0 with no overlay, so Row ends up all zero.
- Row must not change outside COMMIT.
- req while state != IDLE: ignored, overrun pulses for 1 cycle, and the fetch in progress is unaffected.
- req in the COMMIT cycle: also ignored with an overrun pulse. The colour mapper must re-request.
- Reset mid-fetch: the partial row is discarded, Row goes to 0, and no rowReady is issued.
- The piece snapshot is taken at T, so piece moves during a fetch never tear a row.

Optional Feature:
- Macro PIECE_OVERLAY_EN.
- Defined: overlay as described above.
- Undefined: the snapshot registers and comparators are removed, the piece_* ports stay present but are ignored, and Row reflects RAM contents only. Timing is unchanged.

Decomposition:
- Package tetris_pkg holds:
  - BOARD_COLS and BOARD_ROWS localparams;
  - typedef cell_t (16-bit colour cell);
  - typedef fetch_state_t enum {IDLE, FETCH, DRAIN, COMMIT};
  - typedef piece_t (4 x/y pairs plus colour).
- One sub-module: piece_cell_match. It is combinational: (row, col, piece snapshot) -> hit. It is instantiated only under PIECE_OVERLAY_EN.

Test Plan:
- RAM preloaded with cell(r,c)=r*16+c, overlay off. Pulse LD_Row at T with rowNum=3 -> mem_addr 30..39 at T+1..T+10; rowReady at T+12; Row[c]=0x30+c.
- rowNum=25 -> mem_rd never asserts; rowReady at T+12; all Row cells 0x0000.
- Hold LD_Row high for 40 cycles -> exactly one fetch and one rowReady. Rising edge at T+5 during a fetch -> overrun pulse and Row unchanged by it.
- PIECE_OVERLAY_EN, piece cells (4,5),(4,6),(5,5),(3,0), color 0x0F00, rowNum=4 -> Row[5]=Row[6]=0x0F00, all other cells from RAM. With piece_valid=0 -> all cells from RAM.
- Assert reset at T+6 of a fetch -> Row all 0, no rowReady, IDLE. A new request afterwards completes normally in 12 cycles.
- Move the piece at T+4 during a fetch of row 4 -> Row reflects the positions snapshotted at T.
